// File: rtl/seg_display_scroller.sv
// seg_display_scroller: shows a NUM_DIGITS window of a digit buffer on active-high 7-segment displays, static or scrolling.
// Optional blink gating is built only when SEG_BLINK_EN is defined.
module seg_display_scroller #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BUF_DEPTH  = 16,
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned BLINK_DIV  = 12500000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          mode,
  input  logic                          wr_en,
  input  logic [$clog2(BUF_DEPTH)-1:0]  wr_addr,
  input  logic [5:0]                    wr_data,
  input  logic                          blink,
  output logic [NUM_DIGITS*8-1:0]       hex
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned IW = AW + 1;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned HW = NUM_DIGITS * 8;
  localparam logic [5:0]  BLANK_ENTRY = 6'h10;

  logic [5:0]    dbuf [BUF_DEPTH];
  logic [AW-1:0] ptr;
  logic [PW-1:0] presc;
  logic [HW-1:0] win_c;
  logic [HW-1:0] hex_nxt_c;
  logic          dark_c;

  // Hex value to segments a..g in bits 7:1; dp in bit 0 is independent of blank.
  function automatic logic [7:0] seg_encode(input logic [5:0] e);
    logic [7:0] m;
    case (e[3:0])
      4'h0:    m = 8'hFC;
      4'h1:    m = 8'h60;
      4'h2:    m = 8'hDA;
      4'h3:    m = 8'hF2;
      4'h4:    m = 8'h66;
      4'h5:    m = 8'hB6;
      4'h6:    m = 8'hBE;
      4'h7:    m = 8'hE0;
      4'h8:    m = 8'hFE;
      4'h9:    m = 8'hF6;
      4'hA:    m = 8'hEE;
      4'hB:    m = 8'h3E;
      4'hC:    m = 8'h9C;
      4'hD:    m = 8'h7A;
      4'hE:    m = 8'h9E;
      default: m = 8'h8E;
    endcase
    if (e[4]) m = 8'h00;
    return (m & 8'hFE) | {7'h00, e[5]};
  endfunction

  // (p + k) mod BUF_DEPTH; k < NUM_DIGITS <= BUF_DEPTH so one subtraction suffices.
  function automatic logic [AW-1:0] win_idx(input logic [AW-1:0] p, input int unsigned k);
    logic [IW-1:0] s;
    s = {1'b0, p} + IW'(k);
    if (s >= IW'(BUF_DEPTH)) s = s - IW'(BUF_DEPTH);
    return s[AW-1:0];
  endfunction

  always_comb begin
    win_c = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      win_c[8*(NUM_DIGITS-1-k) +: 8] = seg_encode(dbuf[win_idx(ptr, k)]);
    end
    hex_nxt_c = (enable && !dark_c) ? win_c : '0;
  end

  // Buffer, scroll position and registered display.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) dbuf[i] <= BLANK_ENTRY;
      ptr   <= '0;
      presc <= '0;
      hex   <= '0;
    end else begin
      if (wr_en && ({1'b0, wr_addr} < IW'(BUF_DEPTH))) dbuf[wr_addr] <= wr_data;
      if (!mode) begin
        ptr   <= '0;
        presc <= '0;
      end else if (enable) begin
        if (presc == PW'(TICK_DIV - 1)) begin
          presc <= '0;
          ptr   <= (ptr == AW'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
      hex <= hex_nxt_c;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_DIV);

  logic [BW-1:0] bcnt;
  logic          phase_off;

  // Blink phase starts lit and toggles every BLINK_DIV enabled cycles while blink is held.
  always_ff @(posedge clk) begin
    if (rst || !blink) begin
      bcnt      <= '0;
      phase_off <= 1'b0;
    end else if (enable) begin
      if (bcnt == BW'(BLINK_DIV - 1)) begin
        bcnt      <= '0;
        phase_off <= ~phase_off;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  assign dark_c = blink & phase_off;
`else
  logic unused_blink;
  assign unused_blink = blink ^ 1'(BLINK_DIV & 32'd1);
  assign dark_c       = 1'b0;
`endif

endmodule

// File: tb/tb_seg_display_scroller.sv
// Testbench for seg_display_scroller: vector table, directed scroll/blink sequences and randomized run against a reference model.
module tb_seg_display_scroller;

  localparam int ND  = 6;
  localparam int BD  = 8;
  localparam int TD  = 4;
  localparam int BKD = 3;
`ifdef SEG_BLINK_EN
  localparam bit BLINK_BUILT = 1'b1;
`else
  localparam bit BLINK_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, mode, wr_en, blink;
  logic [2:0]  wr_addr;
  logic [5:0]  wr_data;
  logic [47:0] hex;

  always #5 clk = ~clk;

  seg_display_scroller #(
    .NUM_DIGITS(ND), .BUF_DEPTH(BD), .TICK_DIV(TD), .BLINK_DIV(BKD)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .blink(blink), .hex(hex)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  segtab [16];
  logic [5:0]  mbuf [BD];
  int          mptr, mpresc, mbcnt;
  bit          moff;
  logic [47:0] mhex;

  typedef struct {
    logic rst, en, mode, we;
    logic [2:0] addr;
    logic [5:0] data;
    logic chk;
    logic [47:0] exp;
  } vec_t;

  vec_t tv [14];

  function automatic vec_t mk(input logic r, e, m, we, input logic [2:0] a, input logic [5:0] d,
                              input logic c, input logic [47:0] x);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.we = we; v.addr = a; v.data = d; v.chk = c; v.exp = x;
    return v;
  endfunction

  function automatic logic [7:0] seg(input logic [5:0] e);
    logic [7:0] s;
    s = segtab[e[3:0]];
    return {e[4] ? 7'h00 : s[7:1], e[5]};
  endfunction

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs presented before it.
  task automatic model_edge();
    logic [47:0] nx;
    nx = '0;
    if (!rst && enable && !(BLINK_BUILT && blink && moff))
      for (int k = 0; k < ND; k++) nx[8*(ND-1-k) +: 8] = seg(mbuf[(mptr + k) % BD]);
    mhex = nx;
    if (rst) begin
      for (int i = 0; i < BD; i++) mbuf[i] = 6'h10;
      mptr = 0; mpresc = 0; mbcnt = 0; moff = 1'b0;
    end else begin
      if (wr_en && int'(wr_addr) < BD) mbuf[wr_addr] = wr_data;
      if (!mode) begin
        mptr = 0; mpresc = 0;
      end else if (enable) begin
        mpresc++;
        if (mpresc == TD) begin mpresc = 0; mptr = (mptr + 1) % BD; end
      end
      if (!blink) begin
        mbcnt = 0; moff = 1'b0;
      end else if (enable) begin
        mbcnt++;
        if (mbcnt == BKD) begin mbcnt = 0; moff = !moff; end
      end
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check(name, hex, mhex);
  endtask

  task automatic drive(input logic r, e, m, we, input logic [2:0] a, input logic [5:0] d, input logic b);
    rst = r; enable = e; mode = m; wr_en = we; wr_addr = a; wr_data = d; blink = b;
  endtask

  initial begin
    segtab[0]  = 8'hFC; segtab[1]  = 8'h60; segtab[2]  = 8'hDA; segtab[3]  = 8'hF2;
    segtab[4]  = 8'h66; segtab[5]  = 8'hB6; segtab[6]  = 8'hBE; segtab[7]  = 8'hE0;
    segtab[8]  = 8'hFE; segtab[9]  = 8'hF6; segtab[10] = 8'hEE; segtab[11] = 8'h3E;
    segtab[12] = 8'h9C; segtab[13] = 8'h7A; segtab[14] = 8'h9E; segtab[15] = 8'h8E;
    for (int i = 0; i < BD; i++) mbuf[i] = 6'h10;
    mptr = 0; mpresc = 0; mbcnt = 0; moff = 1'b0; mhex = '0;
    drive(1, 0, 0, 0, 3'd0, 6'd0, 0);

    // Static window, enable gating, blank and dp.
    tv[0]  = mk(1, 0, 0, 0, 3'd0, 6'h00, 1, 48'h0);
    tv[1]  = mk(0, 1, 0, 0, 3'd0, 6'h00, 1, 48'h0);
    tv[2]  = mk(0, 1, 0, 1, 3'd0, 6'h02, 1, 48'h0);
    tv[3]  = mk(0, 1, 0, 1, 3'd1, 6'h00, 0, 48'h0);
    tv[4]  = mk(0, 1, 0, 1, 3'd2, 6'h09, 0, 48'h0);
    tv[5]  = mk(0, 1, 0, 1, 3'd3, 6'h00, 0, 48'h0);
    tv[6]  = mk(0, 1, 0, 1, 3'd4, 6'h01, 0, 48'h0);
    tv[7]  = mk(0, 1, 0, 1, 3'd5, 6'h00, 0, 48'h0);
    tv[8]  = mk(0, 1, 0, 0, 3'd0, 6'h00, 1, 48'hDAFCF6FC60FC);
    tv[9]  = mk(0, 0, 0, 0, 3'd0, 6'h00, 1, 48'h0);
    tv[10] = mk(0, 1, 0, 0, 3'd0, 6'h00, 1, 48'hDAFCF6FC60FC);
    tv[11] = mk(0, 1, 0, 1, 3'd2, 6'h13, 1, 48'hDAFCF6FC60FC);
    tv[12] = mk(0, 1, 0, 1, 3'd3, 6'h27, 1, 48'hDAFC00FC60FC);
    tv[13] = mk(0, 1, 0, 0, 3'd0, 6'h00, 1, 48'hDAFC00E160FC);
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].en, tv[i].mode, tv[i].we, tv[i].addr, tv[i].data, 0);
      step("table_model");
      if (tv[i].chk) check($sformatf("table[%0d]", i), hex, tv[i].exp);
    end

    // Scroll: entries 0..7 = 0..7, write colliding with a ptr step, wrap, return to static.
    for (int i = 0; i < BD; i++) begin
      drive(0, 1, 0, 1, 3'(i), 6'(i), 0);
      step("load");
    end
    for (int s = 1; s <= 25; s++) begin
      if (s == 4)      drive(0, 1, 1, 1, 3'd1, 6'h0F, 0);
      else if (s == 6) drive(0, 1, 1, 1, 3'd1, 6'h01, 0);
      else             drive(0, 1, 1, 0, 3'd0, 6'h00, 0);
      step("scroll");
      if (s == 1)  check("hex5_step0", 48'(hex[47:40]), 48'hFC);
      if (s == 5)  check("collide",    48'(hex[47:40]), 48'h8E);
      if (s == 9)  check("hex5_step2", 48'(hex[47:40]), 48'hDA);
      if (s == 25) check("wrap_ptr6",  hex, 48'hBEE0FC60DAF2);
    end
    drive(0, 1, 0, 0, 3'd0, 6'h00, 0);
    step("mode0_a");
    step("mode0_b");
    check("mode0_static", hex, 48'hFC60DAF266B6);

    // Freeze with enable low, then reset mid-scroll.
    drive(0, 1, 1, 0, 3'd0, 6'h00, 0);
    for (int i = 0; i < 10; i++) step("pre_freeze");
    drive(0, 0, 1, 1, 3'd7, 6'h25, 0);
    for (int i = 0; i < 6; i++) step("freeze");
    drive(0, 1, 1, 0, 3'd0, 6'h00, 0);
    for (int i = 0; i < 10; i++) step("thaw");
    drive(1, 1, 1, 0, 3'd0, 6'h00, 0);
    step("mid_reset");
    check("mid_reset_hex", hex, 48'h0);

    // Blink: 3 lit / 3 dark when built, steady otherwise; release shows digits next edge.
    for (int i = 0; i < ND; i++) begin
      drive(0, 1, 0, 1, 3'(i), 6'(i), 0);
      step("blink_load");
    end
    drive(0, 1, 0, 0, 3'd0, 6'h00, 0);
    step("blink_idle");
    drive(0, 1, 0, 0, 3'd0, 6'h00, 1);
    for (int j = 0; j < 10; j++) begin
      step("blink_model");
      check($sformatf("blink[%0d]", j), hex,
            (!BLINK_BUILT || ((j / 3) % 2 == 0)) ? 48'hFC60DAF266B6 : 48'h0);
    end
    drive(0, 1, 0, 0, 3'd0, 6'h00, 0);
    step("unblink_model");
    check("unblink", hex, 48'hFC60DAF266B6);

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if ($urandom_range(0, 14) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) blink = ~blink;
      wr_en   = 1'($urandom());
      wr_addr = 3'($urandom());
      wr_data = 6'($urandom());
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_display_scroller.md
# seg_display_scroller

Parametrised driver for a bank of active-high 7-segment displays (HEX0 rightmost). It holds a digit buffer that firmware or upstream logic writes one entry at a time. It presents a NUM_DIGITS-wide window of that buffer on the HEX outputs, either static or scrolling at a fixed tick rate. It replaces hard-wired per-digit constants and gates all digits with one enable.

## Interface
- NUM_DIGITS, 6: number of displays driven; 1..8.
- BUF_DEPTH, 16: digit buffer entries; NUM_DIGITS..64.
- TICK_DIV, 25000000: clock cycles per scroll step; ≥2.
- BLINK_DIV, 12500000: clock cycles per blink phase; ≥2, used only with SEG_BLINK_EN.
- clk  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  1: digits lit per buffer; 0: all HEX bits 0.
- mode  in  1  0: static window at entry 0; 1: scrolling.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  $clog2(BUF_DEPTH)  entry index; writes with index ≥ BUF_DEPTH are ignored.
- wr_data  in  6  [3:0] hex value, [4] blank, [5] decimal point.
- blink  in  1  request blinking; ignored without SEG_BLINK_EN.
- hex  out  NUM_DIGITS*8  hex[8i+7:8i] = HEXi, bit7=a … bit1=g, bit0=dp, 1=segment lit.

## Operation
- Segment map, bits 7:1 plus dp=0: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E. blank=1 gives 7:1 all zero. wr_data[5] drives bit0 independently of blank.
- Window: the leftmost digit HEX(N-1) shows buf[ptr]. HEX(N-1-k) shows buf[(ptr+k) mod BUF_DEPTH], for k=0..N-1.
- Prescaler counts 0..TICK_DIV-1 and wraps. In mode=1 with enable=1, ptr increments on the wrap cycle. ptr wraps from BUF_DEPTH-1 to 0.
- Taking mode to 0 clears ptr and the prescaler on the next edge. Both stay 0 while mode=0.
- enable=0 freezes ptr and the prescaler. Buffer writes are still accepted.
- Write to the entry currently displayed: the new value appears one cycle later. No tearing, because each output digit is registered as a whole.
- Write on the same edge as a ptr step: both take effect. The output after the following edge uses the new ptr and the new data.

## Timing
- Reset: all buffer entries become blank with dp=0. ptr=0, prescaler=0, hex=0 on the first edge with rst=1. This also applies mid-scroll.
- Outputs are registered: hex on edge k+1 reflects the buffer, ptr and enable as sampled after edge k.
- Write latency: wr_en sampled on edge k shows on hex after edge k+1.
- A ptr step on edge k is visible after edge k+1.
- Scroll period is exactly TICK_DIV cycles per step. A full rotation takes BUF_DEPTH*TICK_DIV cycles.
- enable low→high: digits reappear after the next edge. The scroll position is the frozen one.

## Configuration
- SEG_BLINK_EN defined:
  - A blink counter counts 0..BLINK_DIV-1.
  - The blink phase toggles on each wrap, and phase resets to on.
  - While blink=1 and the phase is off, hex=0. ptr and the buffer are unaffected.
  - When blink deasserts, the counter and phase clear on the next edge and the digits show immediately.
  - The counter runs only while enable=1 and blink=1. Reset clears the counter and phase.
- SEG_BLINK_EN undefined:
  - No blink logic is built. The blink port exists but is ignored.
  - hex depends only on enable, mode and the buffer.

## Test plan
- Reset then enable=1, mode=0, no writes → all hex = 0. Assert rst mid-scroll → hex = 0 and ptr = 0 after one edge.
- Write entries 0..5 = 2,0,9,0,1,0 with enable=1 and mode=0 → HEX5..HEX0 = DA, FC, F6, FC, 60, FC. Drop enable → all 0 next cycle.
- Scroll with TICK_DIV=4, BUF_DEPTH=8, entries 0..7 = 0..7, mode=1:
  - HEX5 steps 0→1→2 every 4 cycles.
  - At ptr=6, HEX5..HEX0 = BE, E0, FC, 60, DA, F2 (wrap).
  - Setting mode=0 returns to entries 0..5 one edge later.
- Write entry 2 = 0x13 (blank) and entry 3 = 0x27 (7, dp) in static mode → HEX3 = 00, HEX2 = E1. A write colliding with a ptr step yields both effects one edge later.
- With SEG_BLINK_EN, BLINK_DIV=3, blink=1 → hex alternates on 3 cycles / 0 for 3 cycles. blink=0 restores digits next edge. Without the macro, blink has no effect.
